axi_arb2: RTL and testbench
===========================

Name: axi_arb2

Overview:
- Two-master to one-slave AXI4 arbiter that shares the single external data bus (`dBus_*`) between the MiniRv32 core bus and a second requester, e.g. a DMA or debug master.
- Sits between the SoC masters and the top-level `dBus` pins.
- Read and write paths are arbitrated independently, round-robin.
- Each path allows one outstanding transaction at a time, so IDs pass through unchanged.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8
ID_W, 16, transaction ID width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
sN_awvalid/sN_awready, N=0,1  in/out  1  upstream AW handshake
sN_awaddr/sN_awid/sN_awlen/sN_awsize/sN_awburst  in  ADDR_W/ID_W/8/3/2  upstream AW payload
sN_wvalid/sN_wready  in/out  1  upstream W handshake
sN_wdata/sN_wstrb/sN_wlast  in  DATA_W/DATA_W/8/1  upstream W payload
sN_bvalid/sN_bready  out/in  1  upstream B handshake
sN_bid/sN_bresp  out  ID_W/2  upstream B payload
sN_arvalid/sN_arready  in/out  1  upstream AR handshake
sN_araddr/sN_arid/sN_arlen/sN_arsize/sN_arburst  in  ADDR_W/ID_W/8/3/2  upstream AR payload
sN_rvalid/sN_rready  out/in  1  upstream R handshake
sN_rdata/sN_rid/sN_rresp/sN_rlast  out  DATA_W/ID_W/2/1  upstream R payload
m_* (aw, w, b, ar, r groups)  mirrored directions  same widths  downstream port, wired to `dBus_*`

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - `rst` is synchronous and active-low: state is cleared on a `clk` edge while `rst`=0.
- Reset values:
  - All valid and ready outputs are 0, both upstream and downstream.
  - Both FSMs are IDLE.
  - Both round-robin pointers favour master 0.
  - Payload outputs are don't-care but driven from the granted master (master 0 at reset).
- Read FSM, states RD_IDLE, RD_ADDR, RD_DATA:
  - RD_IDLE: if any `sN_arvalid` is high, register the grant and go to RD_ADDR. This costs one arbitration cycle; no ready is given in RD_IDLE.
  - Arbitration: if both request, the pointer's master wins. After each grant the pointer moves to the other master.
  - RD_ADDR: `m_ar*` = granted master's AR, combinational. `sG_arready` = `m_arready`. On `m_arvalid && m_arready`, go to RD_DATA.
  - RD_DATA: `sG_r*` = `m_r*`. `m_rready` = `sG_rready`. The ungranted master's `rvalid` is 0. On `m_rvalid && m_rready && m_rlast`, go to RD_IDLE.
- Write FSM, states WR_IDLE, WR_ADDR, WR_DATA, WR_RESP:
  - Arbitration works the same way, using `sN_awvalid` and its own pointer.
  - WR_ADDR: AW is passed through as for AR.
  - WR_DATA: W is passed through from the granted master only. Go to WR_RESP on a W handshake with `wlast`.
  - WR_RESP: B is passed through to the granted master. Go to WR_IDLE on a B handshake.
- Blocking rules:
  - The ungranted master's AW/AR/W ready outputs are always 0.
  - Upstream W presented before AW is held (`wready`=0) until WR_DATA.
- Independence: read and write FSMs run concurrently with no ordering between them. The same master may hold both grants at once.
- Responses:
  - `wlast` and `rlast` are trusted and beats are not counted.
  - `rid`, `bid`, `rresp` and `bresp` pass through unmodified. IDs are not checked.
- Latency:
  - Request to `m_*valid` is 1 cycle.
  - Back-to-back transactions have a 1-cycle bubble in the IDLE state.
  - Data beats pass combinationally with no added latency.
- Reset mid-transaction: the FSM returns to IDLE immediately; in-flight beats are abandoned. The whole system is reset together.
- Upstream valids follow AXI stability rules; no combinational valid-to-ready loop is created.

Decomposition:
- Package `axi_arb2_pkg`:
  - read-state and write-state enums;
  - AXI burst and response constants (INCR=2'b01, OKAY=2'b00).
- Sub-module `rr_arb2`:
  - inputs: two request bits and an advance strobe;
  - outputs: a registered grant index and a valid signal;
  - owns the pointer;
  - instantiated twice, once for read and once for write.

Test Plan:
1. Reset then `rst`=1; only `s0_arvalid`, addr 0x1000, len 0 → `m_arvalid` in cycle 2 with `m_araddr`=0x1000; after one R beat with rlast, `s0_rvalid`=1, `s1_rvalid`=0; FSM back to RD_IDLE.
2. `s0_arvalid` and `s1_arvalid` asserted in the same cycle and held → grant order 0,1,0,1 over four single-beat reads; `rid` values 0x0A and 0x0B are returned to the correct masters.
3. `s1` write: len 3, 4 W beats with data 0x11..0x44 and `wlast` on beat 4; `s0_awvalid` raised mid-burst → `s0_awready` stays 0 until the B handshake for `s1` completes; `m_wdata` sequence is exactly 0x11,0x22,0x33,0x44.
4. `s0` read and `s1` write issued in the same cycle → both `m_arvalid` and `m_awvalid` assert in cycle 2; the transactions complete independently.
5. `m_rready` backpressure: `sG_rready` low for 3 cycles → `m_rready`=0 for those cycles; beat data is held and delivered once.
6. `rst`=0 asserted in RD_DATA after beat 1 of 4 → next cycle all valid/ready outputs are 0 and the FSM is RD_IDLE.

Source files
------------

// File: rtl/axi_arb2_pkg.sv
// Shared types for the two-master AXI4 arbiter.
// FSM state encodings and AXI burst/response codes.
package axi_arb2_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } wr_state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_arb2_rr_arb2.sv
// Two-way round-robin arbiter with a registered grant.
// The pointer flips to the loser after every grant taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt,
  output logic       gnt_valid
);

  logic ptr;
  logic win;

  always_comb begin
    win = req[1];
    if (req[0] && req[1]) win = ptr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr       <= 1'b0;
      gnt       <= 1'b0;
      gnt_valid <= 1'b0;
    end else if (advance) begin
      gnt_valid <= |req;
      if (|req) begin
        gnt <= win;
        ptr <= ~win;
      end
    end
  end

endmodule

// File: rtl/axi_arb2.sv
// Two-master to one-slave AXI4 arbiter, one outstanding
// transaction per direction, independent RR for read/write.
module axi_arb2
  import axi_arb2_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s0_awvalid,
  output logic                s0_awready,
  input  logic [ADDR_W-1:0]   s0_awaddr,
  input  logic [ID_W-1:0]     s0_awid,
  input  logic [7:0]          s0_awlen,
  input  logic [2:0]          s0_awsize,
  input  logic [1:0]          s0_awburst,
  input  logic                s0_wvalid,
  output logic                s0_wready,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  input  logic                s0_wlast,
  output logic                s0_bvalid,
  input  logic                s0_bready,
  output logic [ID_W-1:0]     s0_bid,
  output logic [1:0]          s0_bresp,
  input  logic                s0_arvalid,
  output logic                s0_arready,
  input  logic [ADDR_W-1:0]   s0_araddr,
  input  logic [ID_W-1:0]     s0_arid,
  input  logic [7:0]          s0_arlen,
  input  logic [2:0]          s0_arsize,
  input  logic [1:0]          s0_arburst,
  output logic                s0_rvalid,
  input  logic                s0_rready,
  output logic [DATA_W-1:0]   s0_rdata,
  output logic [ID_W-1:0]     s0_rid,
  output logic [1:0]          s0_rresp,
  output logic                s0_rlast,
  input  logic                s1_awvalid,
  output logic                s1_awready,
  input  logic [ADDR_W-1:0]   s1_awaddr,
  input  logic [ID_W-1:0]     s1_awid,
  input  logic [7:0]          s1_awlen,
  input  logic [2:0]          s1_awsize,
  input  logic [1:0]          s1_awburst,
  input  logic                s1_wvalid,
  output logic                s1_wready,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  input  logic                s1_wlast,
  output logic                s1_bvalid,
  input  logic                s1_bready,
  output logic [ID_W-1:0]     s1_bid,
  output logic [1:0]          s1_bresp,
  input  logic                s1_arvalid,
  output logic                s1_arready,
  input  logic [ADDR_W-1:0]   s1_araddr,
  input  logic [ID_W-1:0]     s1_arid,
  input  logic [7:0]          s1_arlen,
  input  logic [2:0]          s1_arsize,
  input  logic [1:0]          s1_arburst,
  output logic                s1_rvalid,
  input  logic                s1_rready,
  output logic [DATA_W-1:0]   s1_rdata,
  output logic [ID_W-1:0]     s1_rid,
  output logic [1:0]          s1_rresp,
  output logic                s1_rlast,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [ID_W-1:0]     m_awid,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [ID_W-1:0]     m_bid,
  input  logic [1:0]          m_bresp,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [ID_W-1:0]     m_arid,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [ID_W-1:0]     m_rid,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast
);

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;

  logic rg, rgv, wg, wgv;
  logic rd_addr, rd_data;
  logic wr_addr, wr_data, wr_resp;

  rr_arb2 u_rd_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({s1_arvalid, s0_arvalid}),
    .advance   (rd_state == RD_IDLE),
    .gnt       (rg),
    .gnt_valid (rgv)
  );

  rr_arb2 u_wr_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({s1_awvalid, s0_awvalid}),
    .advance   (wr_state == WR_IDLE),
    .gnt       (wg),
    .gnt_valid (wgv)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_state <= RD_IDLE;
      wr_state <= WR_IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE:
        if (s0_arvalid || s1_arvalid) rd_next = RD_ADDR;
      RD_ADDR:
        if (m_arvalid && m_arready) rd_next = RD_DATA;
      RD_DATA:
        if (m_rvalid && m_rready && m_rlast) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE:
        if (s0_awvalid || s1_awvalid) wr_next = WR_ADDR;
      WR_ADDR:
        if (m_awvalid && m_awready) wr_next = WR_DATA;
      WR_DATA:
        if (m_wvalid && m_wready && m_wlast) wr_next = WR_RESP;
      WR_RESP:
        if (m_bvalid && m_bready) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  // Read path: payload always muxed from the grant, handshakes gated by state
  assign rd_addr = (rd_state == RD_ADDR) && rgv;
  assign rd_data = (rd_state == RD_DATA);

  assign m_arvalid = rd_addr && (rg ? s1_arvalid : s0_arvalid);
  assign m_araddr  = rg ? s1_araddr  : s0_araddr;
  assign m_arid    = rg ? s1_arid    : s0_arid;
  assign m_arlen   = rg ? s1_arlen   : s0_arlen;
  assign m_arsize  = rg ? s1_arsize  : s0_arsize;
  assign m_arburst = rg ? s1_arburst : s0_arburst;

  assign s0_arready = rd_addr && !rg && m_arready;
  assign s1_arready = rd_addr &&  rg && m_arready;

  assign m_rready  = rd_data && (rg ? s1_rready : s0_rready);
  assign s0_rvalid = rd_data && !rg && m_rvalid;
  assign s1_rvalid = rd_data &&  rg && m_rvalid;
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rid    = m_rid;
  assign s1_rid    = m_rid;
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;
  assign s1_rlast  = m_rlast;

  // Write path: W from the loser stays stalled until its own WR_DATA
  assign wr_addr = (wr_state == WR_ADDR) && wgv;
  assign wr_data = (wr_state == WR_DATA);
  assign wr_resp = (wr_state == WR_RESP);

  assign m_awvalid = wr_addr && (wg ? s1_awvalid : s0_awvalid);
  assign m_awaddr  = wg ? s1_awaddr  : s0_awaddr;
  assign m_awid    = wg ? s1_awid    : s0_awid;
  assign m_awlen   = wg ? s1_awlen   : s0_awlen;
  assign m_awsize  = wg ? s1_awsize  : s0_awsize;
  assign m_awburst = wg ? s1_awburst : s0_awburst;

  assign s0_awready = wr_addr && !wg && m_awready;
  assign s1_awready = wr_addr &&  wg && m_awready;

  assign m_wvalid = wr_data && (wg ? s1_wvalid : s0_wvalid);
  assign m_wdata  = wg ? s1_wdata : s0_wdata;
  assign m_wstrb  = wg ? s1_wstrb : s0_wstrb;
  assign m_wlast  = wg ? s1_wlast : s0_wlast;

  assign s0_wready = wr_data && !wg && m_wready;
  assign s1_wready = wr_data &&  wg && m_wready;

  assign m_bready  = wr_resp && (wg ? s1_bready : s0_bready);
  assign s0_bvalid = wr_resp && !wg && m_bvalid;
  assign s1_bvalid = wr_resp &&  wg && m_bvalid;
  assign s0_bid    = m_bid;
  assign s1_bid    = m_bid;
  assign s0_bresp  = m_bresp;
  assign s1_bresp  = m_bresp;

endmodule

// File: tb/tb_axi_arb2.sv
// Bench for axi_arb2: directed masters, reactive slave,
// queue scoreboard checked by a negedge monitor.
module tb_axi_arb2;
  import axi_arb2_pkg::*;

  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        aw_valid [2];
  logic        aw_ready [2];
  logic [31:0] aw_addr  [2];
  logic [15:0] aw_id    [2];
  logic [7:0]  aw_len   [2];
  logic [2:0]  aw_size  [2];
  logic [1:0]  aw_burst [2];
  logic        w_valid  [2];
  logic        w_ready  [2];
  logic [31:0] w_data   [2];
  logic [3:0]  w_strb   [2];
  logic        w_last   [2];
  logic        b_valid  [2];
  logic        b_ready  [2];
  logic [15:0] b_id     [2];
  logic [1:0]  b_resp   [2];
  logic        ar_valid [2];
  logic        ar_ready [2];
  logic [31:0] ar_addr  [2];
  logic [15:0] ar_id    [2];
  logic [7:0]  ar_len   [2];
  logic [2:0]  ar_size  [2];
  logic [1:0]  ar_burst [2];
  logic        r_valid  [2];
  logic        r_ready  [2];
  logic [31:0] r_data   [2];
  logic [15:0] r_id     [2];
  logic [1:0]  r_resp   [2];
  logic        r_last   [2];

  logic        m_awvalid, m_awready;
  logic [31:0] m_awaddr;
  logic [15:0] m_awid;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_wvalid, m_wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_bvalid, m_bready;
  logic [15:0] m_bid;
  logic [1:0]  m_bresp;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [15:0] m_arid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic [15:0] m_rid;
  logic [1:0]  m_rresp;
  logic        m_rlast;

  axi_arb2 #(.ADDR_W(32), .DATA_W(32), .ID_W(16)) dut (
    .clk(clk), .rst(rst),
    .s0_awvalid(aw_valid[0]), .s0_awready(aw_ready[0]),
    .s0_awaddr(aw_addr[0]), .s0_awid(aw_id[0]),
    .s0_awlen(aw_len[0]), .s0_awsize(aw_size[0]),
    .s0_awburst(aw_burst[0]),
    .s0_wvalid(w_valid[0]), .s0_wready(w_ready[0]),
    .s0_wdata(w_data[0]), .s0_wstrb(w_strb[0]),
    .s0_wlast(w_last[0]),
    .s0_bvalid(b_valid[0]), .s0_bready(b_ready[0]),
    .s0_bid(b_id[0]), .s0_bresp(b_resp[0]),
    .s0_arvalid(ar_valid[0]), .s0_arready(ar_ready[0]),
    .s0_araddr(ar_addr[0]), .s0_arid(ar_id[0]),
    .s0_arlen(ar_len[0]), .s0_arsize(ar_size[0]),
    .s0_arburst(ar_burst[0]),
    .s0_rvalid(r_valid[0]), .s0_rready(r_ready[0]),
    .s0_rdata(r_data[0]), .s0_rid(r_id[0]),
    .s0_rresp(r_resp[0]), .s0_rlast(r_last[0]),
    .s1_awvalid(aw_valid[1]), .s1_awready(aw_ready[1]),
    .s1_awaddr(aw_addr[1]), .s1_awid(aw_id[1]),
    .s1_awlen(aw_len[1]), .s1_awsize(aw_size[1]),
    .s1_awburst(aw_burst[1]),
    .s1_wvalid(w_valid[1]), .s1_wready(w_ready[1]),
    .s1_wdata(w_data[1]), .s1_wstrb(w_strb[1]),
    .s1_wlast(w_last[1]),
    .s1_bvalid(b_valid[1]), .s1_bready(b_ready[1]),
    .s1_bid(b_id[1]), .s1_bresp(b_resp[1]),
    .s1_arvalid(ar_valid[1]), .s1_arready(ar_ready[1]),
    .s1_araddr(ar_addr[1]), .s1_arid(ar_id[1]),
    .s1_arlen(ar_len[1]), .s1_arsize(ar_size[1]),
    .s1_arburst(ar_burst[1]),
    .s1_rvalid(r_valid[1]), .s1_rready(r_ready[1]),
    .s1_rdata(r_data[1]), .s1_rid(r_id[1]),
    .s1_rresp(r_resp[1]), .s1_rlast(r_last[1]),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_bid(m_bid), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rid(m_rid),
    .m_rresp(m_rresp), .m_rlast(m_rlast)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] id;
    logic [7:0]  len;
  } ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] id;
    logic        last;
  } rx_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } wx_t;

  ax_t         arq[$], awq[$];
  rx_t         rq0[$], rq1[$];
  wx_t         wq[$];
  logic [15:0] bq0[$], bq1[$];

  ax_t         ea;
  rx_t         er;
  wx_t         ew;
  logic [15:0] eb;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic b1_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int which, input int m);
    case (which)
      0: return ar_valid[m] && ar_ready[m];
      1: return aw_valid[m] && aw_ready[m];
      2: return w_valid[m] && w_ready[m];
      3: return r_valid[m];
      4: return r_valid[m] && r_ready[m];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [14:0] outs();
    return {ar_ready[0], ar_ready[1], aw_ready[0], aw_ready[1],
            w_ready[0], w_ready[1], b_valid[0], b_valid[1],
            r_valid[0], r_valid[1], m_arvalid, m_awvalid,
            m_wvalid, m_bready, m_rready};
  endfunction

  task automatic wait_for(input int which, input int m, input string nm);
    int t;
    for (t = 0; t < TMO; t++) begin
      @(negedge clk);
      if (sig(which, m)) break;
    end
    if (t == TMO) chk(nm, 32'd0, 32'd1);
  endtask

  task automatic exp_read(input int m, input logic [31:0] a,
                          input logic [15:0] id, input logic [7:0] len);
    arq.push_back('{a, id, len});
    for (int k = 0; k <= int'(len); k++) begin
      if (m == 0) rq0.push_back('{a + 32'(k), id, k == int'(len)});
      else        rq1.push_back('{a + 32'(k), id, k == int'(len)});
    end
  endtask

  task automatic exp_write(input int m, input logic [31:0] a,
                           input logic [15:0] id, input int n,
                           input logic [31:0] base);
    awq.push_back('{a, id, 8'(n - 1)});
    for (int k = 0; k < n; k++)
      wq.push_back('{base * 32'(k + 1), k == n - 1});
    if (m == 0) bq0.push_back(id);
    else        bq1.push_back(id);
  endtask

  task automatic do_read(input int m, input logic [31:0] a,
                         input logic [15:0] id, input logic [7:0] len);
    ar_addr[m]  = a;
    ar_id[m]    = id;
    ar_len[m]   = len;
    ar_size[m]  = 3'd2;
    ar_burst[m] = BURST_INCR;
    ar_valid[m] = 1'b1;
    wait_for(0, m, "ar_hs_timeout");
    @(posedge clk); #1;
    ar_valid[m] = 1'b0;
  endtask

  task automatic do_write(input int m, input logic [31:0] a,
                          input logic [15:0] id, input int n,
                          input logic [31:0] base);
    fork
      begin
        aw_addr[m]  = a;
        aw_id[m]    = id;
        aw_len[m]   = 8'(n - 1);
        aw_size[m]  = 3'd2;
        aw_burst[m] = BURST_INCR;
        aw_valid[m] = 1'b1;
        wait_for(1, m, "aw_hs_timeout");
        @(posedge clk); #1;
        aw_valid[m] = 1'b0;
      end
      begin
        for (int k = 0; k < n; k++) begin
          w_data[m]  = base * 32'(k + 1);
          w_strb[m]  = 4'hf;
          w_last[m]  = (k == n - 1);
          w_valid[m] = 1'b1;
          wait_for(2, m, "w_hs_timeout");
          @(posedge clk); #1;
        end
        w_valid[m] = 1'b0;
        w_last[m]  = 1'b0;
      end
    join
  endtask

  task automatic flush();
    arq.delete(); awq.delete(); wq.delete();
    rq0.delete(); rq1.delete(); bq0.delete(); bq1.delete();
  endtask

  function automatic int pending();
    return arq.size() + awq.size() + wq.size() + rq0.size() +
           rq1.size() + bq0.size() + bq1.size();
  endfunction

  task automatic drain(input string nm);
    for (int t = 0; t < TMO; t++) begin
      if (pending() == 0) break;
      @(negedge clk);
    end
    chk(nm, 32'(pending()), 32'd0);
  endtask

  task automatic clear_drives();
    for (int m = 0; m < 2; m++) begin
      aw_valid[m] = 0; aw_addr[m] = 0; aw_id[m] = 0; aw_len[m] = 0;
      aw_size[m] = 0; aw_burst[m] = 0;
      w_valid[m] = 0; w_data[m] = 0; w_strb[m] = 0; w_last[m] = 0;
      ar_valid[m] = 0; ar_addr[m] = 0; ar_id[m] = 0; ar_len[m] = 0;
      ar_size[m] = 0; ar_burst[m] = 0;
      r_ready[m] = 1; b_ready[m] = 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_drives();
    repeat (2) @(posedge clk);
    #1;
    flush();
    b1_done = 1'b0;
    rst = 1'b1;
  endtask

  // Reactive read slave: rdata = araddr + beat, rid echoes arid
  initial begin : rd_slave
    logic        hs_ar, hs_r, rs;
    logic [31:0] a;
    logic [15:0] i;
    logic [7:0]  l;
    int          beat;
    m_arready = 1; m_rvalid = 0; m_rdata = 0; m_rid = 0;
    m_rresp = RESP_OKAY; m_rlast = 0;
    a = 0; i = 0; l = 0; beat = 0;
    forever begin
      @(negedge clk);
      rs    = rst;
      hs_ar = m_arvalid && m_arready;
      hs_r  = m_rvalid && m_rready;
      if (hs_ar) begin a = m_araddr; i = m_arid; l = m_arlen; end
      @(posedge clk); #1;
      if (!rs) begin
        m_rvalid = 0;
        m_rlast  = 0;
      end else begin
        if (hs_r) begin
          if (m_rlast) m_rvalid = 0;
          else begin
            beat++;
            m_rdata = a + 32'(beat);
            m_rlast = (beat == int'(l));
          end
        end
        if (hs_ar) begin
          beat = 0; m_rvalid = 1; m_rdata = a;
          m_rid = i; m_rlast = (l == 8'd0);
        end
      end
    end
  end

  initial begin : wr_slave
    logic        hs_aw, hs_w, hs_b, rs;
    logic [15:0] i;
    m_awready = 1; m_wready = 1; m_bvalid = 0; m_bid = 0;
    m_bresp = RESP_OKAY; i = 0;
    forever begin
      @(negedge clk);
      rs    = rst;
      hs_aw = m_awvalid && m_awready;
      hs_w  = m_wvalid && m_wready && m_wlast;
      hs_b  = m_bvalid && m_bready;
      if (hs_aw) i = m_awid;
      @(posedge clk); #1;
      if (!rs) m_bvalid = 0;
      else begin
        if (hs_b) m_bvalid = 0;
        if (hs_w) begin m_bvalid = 1; m_bid = i; end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (m_arvalid && m_arready) begin
        if (arq.size() == 0) chk("ar_unexpected", 32'd1, 32'd0);
        else begin
          ea = arq.pop_front();
          chk("m_araddr", m_araddr, ea.addr);
          chk("m_arid", 32'(m_arid), 32'(ea.id));
          chk("m_arlen", 32'(m_arlen), 32'(ea.len));
        end
      end
      if (m_awvalid && m_awready) begin
        if (awq.size() == 0) chk("aw_unexpected", 32'd1, 32'd0);
        else begin
          ea = awq.pop_front();
          chk("m_awaddr", m_awaddr, ea.addr);
          chk("m_awid", 32'(m_awid), 32'(ea.id));
          chk("m_awlen", 32'(m_awlen), 32'(ea.len));
        end
      end
      if (m_wvalid && m_wready) begin
        if (wq.size() == 0) chk("w_unexpected", 32'd1, 32'd0);
        else begin
          ew = wq.pop_front();
          chk("m_wdata", m_wdata, ew.data);
          chk("m_wlast", 32'(m_wlast), 32'(ew.last));
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (r_valid[m] && r_ready[m]) begin
          if ((m == 0 ? rq0.size() : rq1.size()) == 0)
            chk(m == 0 ? "r0_unexpected" : "r1_unexpected", 32'd1, 32'd0);
          else begin
            if (m == 0) er = rq0.pop_front();
            else        er = rq1.pop_front();
            chk("rdata", r_data[m], er.data);
            chk("rid", 32'(r_id[m]), 32'(er.id));
            chk("rlast", 32'(r_last[m]), 32'(er.last));
            chk("rresp", 32'(r_resp[m]), 32'(RESP_OKAY));
          end
        end
        if (b_valid[m] && b_ready[m]) begin
          if ((m == 0 ? bq0.size() : bq1.size()) == 0)
            chk(m == 0 ? "b0_unexpected" : "b1_unexpected", 32'd1, 32'd0);
          else begin
            if (m == 0) eb = bq0.pop_front();
            else        eb = bq1.pop_front();
            chk("bid", 32'(b_id[m]), 32'(eb));
            chk("bresp", 32'(b_resp[m]), 32'(RESP_OKAY));
            if (m == 1) b1_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int viol;
    clear_drives();
    ar_addr[0] = 32'hAAAA_0000;
    ar_addr[1] = 32'h5555_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", 32'(outs()), 32'd0);
    chk("rst_rd_state", 32'(dut.rd_state), 32'(RD_IDLE));
    chk("rst_wr_state", 32'(dut.wr_state), 32'(WR_IDLE));
    chk("rst_araddr_m0", m_araddr, 32'hAAAA_0000);

    // 1: single read from master 0
    do_reset();
    exp_read(0, 32'h1000, 16'h0001, 8'd0);
    fork
      do_read(0, 32'h1000, 16'h0001, 8'd0);
      begin
        @(negedge clk);
        chk("t1_arvalid_c1", 32'(m_arvalid), 32'd0);
        @(negedge clk);
        chk("t1_arvalid_c2", 32'(m_arvalid), 32'd1);
        chk("t1_araddr_c2", m_araddr, 32'h1000);
      end
    join
    wait_for(3, 0, "t1_rvalid_timeout");
    chk("t1_s1_rvalid", 32'(r_valid[1]), 32'd0);
    drain("t1_drain");
    @(negedge clk);
    chk("t1_rd_idle", 32'(dut.rd_state), 32'(RD_IDLE));

    // 2: both masters contend, grants alternate 0,1,0,1
    do_reset();
    exp_read(0, 32'h2000, 16'h000A, 8'd0);
    exp_read(1, 32'h3000, 16'h000B, 8'd0);
    exp_read(0, 32'h2100, 16'h000A, 8'd0);
    exp_read(1, 32'h3100, 16'h000B, 8'd0);
    fork
      begin
        do_read(0, 32'h2000, 16'h000A, 8'd0);
        do_read(0, 32'h2100, 16'h000A, 8'd0);
      end
      begin
        do_read(1, 32'h3000, 16'h000B, 8'd0);
        do_read(1, 32'h3100, 16'h000B, 8'd0);
      end
    join
    drain("t2_drain");

    // 3: s1 burst write, s0 AW raised mid-burst must wait for s1's B
    do_reset();
    exp_write(1, 32'h4000, 16'h001B, 4, 32'h11);
    exp_write(0, 32'h5000, 16'h001A, 1, 32'h55);
    viol = 0;
    fork
      do_write(1, 32'h4000, 16'h001B, 4, 32'h11);
      begin
        repeat (3) @(posedge clk);
        #1;
        do_write(0, 32'h5000, 16'h001A, 1, 32'h55);
      end
      begin
        for (int t = 0; t < TMO; t++) begin
          @(negedge clk);
          if (aw_ready[0] && !b1_done) viol++;
          if (aw_valid[0] && aw_ready[0]) break;
        end
      end
    join
    chk("t3_s0_aw_blocked", 32'(viol), 32'd0);
    chk("t3_b1_done", 32'(b1_done), 32'd1);
    drain("t3_drain");

    // 4: concurrent read and write
    do_reset();
    exp_read(0, 32'h6000, 16'h000C, 8'd0);
    exp_write(1, 32'h7000, 16'h001D, 1, 32'h66);
    fork
      do_read(0, 32'h6000, 16'h000C, 8'd0);
      do_write(1, 32'h7000, 16'h001D, 1, 32'h66);
      begin
        @(negedge clk);
        chk("t4_valids_c1", 32'({m_arvalid, m_awvalid}), 32'd0);
        @(negedge clk);
        chk("t4_valids_c2", 32'({m_arvalid, m_awvalid}), 32'd3);
      end
    join
    drain("t4_drain");

    // 5: upstream R backpressure for three cycles
    do_reset();
    r_ready[0] = 1'b0;
    exp_read(0, 32'h9000, 16'h000D, 8'd0);
    do_read(0, 32'h9000, 16'h000D, 8'd0);
    wait_for(3, 0, "t5_rvalid_timeout");
    for (int k = 0; k < 3; k++) begin
      chk("t5_m_rready", 32'(m_rready), 32'd0);
      chk("t5_rvalid_held", 32'(r_valid[0]), 32'd1);
      chk("t5_rdata_held", r_data[0], 32'h9000);
      if (k < 2) @(negedge clk);
    end
    @(posedge clk); #1;
    r_ready[0] = 1'b1;
    drain("t5_drain");

    // 6: reset while in RD_DATA after the first of four beats
    do_reset();
    exp_read(0, 32'h8000, 16'h000E, 8'd3);
    do_read(0, 32'h8000, 16'h000E, 8'd3);
    wait_for(4, 0, "t6_beat1_timeout");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_outs", 32'(outs()), 32'd0);
    chk("t6_rd_idle", 32'(dut.rd_state), 32'(RD_IDLE));
    chk("t6_beats_left", 32'(rq0.size()), 32'd3);
    @(posedge clk); #1;
    flush();
    rst = 1'b1;
    exp_read(1, 32'hA000, 16'h000F, 8'd1);
    do_read(1, 32'hA000, 16'h000F, 8'd1);
    drain("t6_recover_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
